gige_rx_pre: RTL
================

// Module: gige_rx_pre
// PURPOSE
//  Receive front-end ahead of gige_rx/gige_s2p. Takes raw GMII (1G) or MII-on-GMII (10/100) receive pins,
//  validates preamble/SFD, strips them, assembles nibbles into bytes at 10/100, and enforces max frame length.
//  Emits per-byte data with frame-valid, first-byte (pdet) and end-of-frame status into gige_s2p's inputs.
// PARAMETERS
//  MIN_PRE   1     minimum count of 0x55 bytes (1G) or byte-equivalents (10/100) before SFD
//  MAX_LEN   1522  maximum post-SFD bytes; byte MAX_LEN+1 truncates the frame
// PORTS
//  clk          in   1   single clock (GMII rx clock domain); all logic on rising edge
//  reset_       in   1   asynchronous, active-low reset
//  fmac_speed   in   2   2'b10=1G bytes on rxd[7:0]; 2'b01/2'b00=10/100 nibbles on rxd[3:0]
//  gmii_rxd     in   8   receive data
//  gmii_rx_dv   in   1   receive data valid
//  gmii_rx_er   in   1   receive error
//  data_out     out  8   stripped frame byte (to gige_s2p data_in)
//  byte_vld     out  1   data_out valid this cycle
//  rx_dv_out    out  1   high from first frame byte through last (to gige_s2p gmii_rx_dv)
//  pdet_out     out  1   one-cycle pulse with the first frame byte (to gige_s2p pdet_in)
//  frame_end    out  1   one-cycle pulse, cycle after last byte_vld of a frame
//  frame_len    out  16  post-SFD byte count; valid with frame_end
//  frame_err    out  1   valid with frame_end: rx_er seen, truncated, or dribble nibble
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters 0; nibble holding register cleared. Reset mid-frame abandons it.
//  Speed latched on IDLE->PRE; ignored until the next IDLE.
//  FSM states IDLE, PRE, DATA, DROP:
//   IDLE: rx_dv=1 and symbol==0x55 (1G byte / nibble 0x5) -> PRE, pre_cnt=1. Other symbol with dv -> DROP.
//   PRE : 0x55 -> pre_cnt++ (saturates at 255). SFD with pre_cnt>=MIN_PRE -> DATA, len=0.
//         SFD = byte 0xD5 (1G) or nibble 0xD after a 0x5 nibble (10/100).
//         SFD with pre_cnt<MIN_PRE, any other symbol, or rx_er -> DROP. dv low -> IDLE, no frame_end.
//   DATA: each byte -> data_out, byte_vld=1, len++. First byte: pdet_out=1, rx_dv_out rises.
//         rx_er high on any data cycle sets sticky err.
//         dv low -> IDLE; next cycle rx_dv_out=0, frame_end=1, frame_len=len, frame_err=err.
//         Byte MAX_LEN+1 arrives -> not output; rx_dv_out drops; frame_end with len=MAX_LEN and frame_err=1; -> DROP.
//   DROP: outputs idle; stays until dv low, then -> IDLE. No frame_end unless entered by truncation.
//  Latency 1G: gmii_rxd byte at cycle N -> data_out/byte_vld at N+1; byte_vld high every DATA cycle.
//  Latency 10/100: low nibble first, high second. Byte = {hi,lo} output the cycle after the high nibble.
//   byte_vld every 2nd cycle; rx_dv_out held high between.
//  Dribble: dv drops with a lone low nibble held -> nibble discarded; frame_err=1 at frame_end.
//  rx_dv=0 with rx_er=1 (carrier ext./false carrier) ignored in IDLE.
//  frame_len 16-bit; cannot wrap since len<=MAX_LEN. frame_end and a new frame's pdet never coincide
//   (at least one IDLE cycle between them).
// TESTING
//  1G: 7x0x55,0xD5, then 64 bytes 0x00..0x3F -> 64 byte_vld, pdet with 0x00, frame_end len=64, err=0.
//  100M: nibbles 5x15, then 5,D, then 60 bytes -> bytes assembled low-first, byte_vld every 2 clk,
//   frame_end len=60, err=0.
//  1G 64B frame with rx_er on byte 10 -> all 64 bytes output, frame_end len=64, frame_err=1.
//  1G 1600B frame with MAX_LEN=1522 -> 1522 byte_vld, rx_dv_out drops, frame_end len=1522, err=1;
//   rest dropped until dv low.
//  Preamble 0x55,0x5A,0xD5 -> DROP: no byte_vld, pdet, or frame_end; next good frame received normally.
//  reset_ low at byte 20 of a 1G frame -> all outputs 0 asynchronously; next frame after release clean, len correct.

Source files
------------

// File: rtl/gige_rx_pre.sv
// ---------------------------------------------------------------------------
// gige_rx_pre
//   Receive front-end that sits ahead of gige_rx/gige_s2p. It checks the
//   preamble and SFD on raw GMII (1G) or MII-on-GMII (10/100) receive pins
//   and strips them. At 10/100 it assembles nibbles into bytes, low nibble
//   first. It also enforces a maximum post-SFD frame length.
//
// Ports
//   clk          in   1   GMII receive clock; all logic on the rising edge
//   reset_       in   1   asynchronous, active-low reset
//   fmac_speed   in   2   2'b10 = 1G bytes, otherwise 10/100 nibbles on rxd[3:0]
//   gmii_rxd     in   8   receive data
//   gmii_rx_dv   in   1   receive data valid
//   gmii_rx_er   in   1   receive error
//   data_out     out  8   stripped frame byte
//   byte_vld     out  1   data_out valid this cycle
//   rx_dv_out    out  1   high from the first frame byte through the last
//   pdet_out     out  1   one-cycle pulse with the first frame byte
//   frame_end    out  1   one-cycle pulse after the last byte of a frame
//   frame_len    out  16  post-SFD byte count, valid with frame_end
//   frame_err    out  1   rx_er seen, truncated or dribble nibble; valid with frame_end
// ---------------------------------------------------------------------------
module gige_rx_pre #(
    parameter int unsigned MIN_PRE = 1,
    parameter int unsigned MAX_LEN = 1522
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [1:0]  fmac_speed,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  data_out,
    output logic        byte_vld,
    output logic        rx_dv_out,
    output logic        pdet_out,
    output logic        frame_end,
    output logic [15:0] frame_len,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } state_t;

    // In nibble mode the preamble counter counts nibbles, so the
    // byte-equivalent threshold doubles.
    localparam logic [8:0]  PRE_NEED_1G  = 9'(MIN_PRE);
    localparam logic [8:0]  PRE_NEED_NIB = 9'(2 * MIN_PRE);
    localparam logic [15:0] LEN_MAX      = 16'(MAX_LEN);

    state_t      r_state;
    logic        r_is_1g;
    logic [7:0]  r_pre_cnt;
    logic [15:0] r_len;
    logic        r_err;
    logic [3:0]  r_nib;
    logic        r_have_lo;

    logic [3:0]  w_nib;
    logic        w_in_1g;
    logic        w_idle_pre;
    logic        w_pre_sym;
    logic        w_sfd;
    logic        w_pre_ok;
    logic [7:0]  w_byte;
    logic        w_at_max;

    always_comb begin
        w_nib      = gmii_rxd[3:0];
        w_in_1g    = (fmac_speed == 2'b10);
        // Speed is not yet latched in IDLE, so use the live pin.
        w_idle_pre = w_in_1g ? (gmii_rxd == 8'h55) : (w_nib == 4'h5);
        w_pre_sym  = r_is_1g ? (gmii_rxd == 8'h55) : (w_nib == 4'h5);
        // In nibble mode every symbol accepted in PRE is a 0x5 nibble.
        // A 0xD nibble seen there therefore always follows a 0x5.
        w_sfd      = r_is_1g ? (gmii_rxd == 8'hD5) : (w_nib == 4'hD);
        w_pre_ok   = r_is_1g ? ({1'b0, r_pre_cnt} >= PRE_NEED_1G)
                             : ({1'b0, r_pre_cnt} >= PRE_NEED_NIB);
        w_byte     = r_is_1g ? gmii_rxd : {w_nib, r_nib};
        w_at_max   = (r_len == LEN_MAX);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state   <= ST_IDLE;
            r_is_1g   <= 1'b0;
            r_pre_cnt <= '0;
            r_len     <= '0;
            r_err     <= 1'b0;
            r_nib     <= '0;
            r_have_lo <= 1'b0;
            data_out  <= '0;
            byte_vld  <= 1'b0;
            rx_dv_out <= 1'b0;
            pdet_out  <= 1'b0;
            frame_end <= 1'b0;
            frame_len <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            pdet_out  <= 1'b0;
            frame_end <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (gmii_rx_dv) begin
                        if (w_idle_pre) begin
                            r_state   <= ST_PRE;
                            r_pre_cnt <= 8'd1;
                            r_is_1g   <= w_in_1g;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_PRE: begin
                    if (!gmii_rx_dv) begin
                        r_state <= ST_IDLE;
                    end else if (gmii_rx_er) begin
                        r_state <= ST_DROP;
                    end else if (w_pre_sym) begin
                        if (r_pre_cnt != 8'hFF) begin
                            r_pre_cnt <= r_pre_cnt + 8'd1;
                        end
                    end else if (w_sfd && w_pre_ok) begin
                        r_state   <= ST_DATA;
                        r_len     <= '0;
                        r_err     <= 1'b0;
                        r_have_lo <= 1'b0;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (!gmii_rx_dv) begin
                        // A lone low nibble still held here is a dribble nibble.
                        r_state   <= ST_IDLE;
                        rx_dv_out <= 1'b0;
                        frame_end <= 1'b1;
                        frame_len <= r_len;
                        frame_err <= r_err | r_have_lo;
                        r_have_lo <= 1'b0;
                    end else begin
                        if (gmii_rx_er) begin
                            r_err <= 1'b1;
                        end
                        if (!r_is_1g && !r_have_lo) begin
                            r_nib     <= w_nib;
                            r_have_lo <= 1'b1;
                        end else begin
                            r_have_lo <= 1'b0;
                            if (w_at_max) begin
                                // Byte MAX_LEN+1: close the frame as truncated.
                                r_state   <= ST_DROP;
                                rx_dv_out <= 1'b0;
                                frame_end <= 1'b1;
                                frame_len <= r_len;
                                frame_err <= 1'b1;
                            end else begin
                                data_out  <= w_byte;
                                byte_vld  <= 1'b1;
                                rx_dv_out <= 1'b1;
                                pdet_out  <= (r_len == 16'd0);
                                r_len     <= r_len + 16'd1;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (!gmii_rx_dv) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
